uart_loader: RTL and testbench

- Serial boot loader between the UART receiver and main memory.
- Consumes received bytes (rxchar/rxvalid), parses a framed binary image and writes 32-bit words into main memory over the CPU-side memory write port.
- Holds the CPU in reset while a load is in progress.
- Lets images be downloaded without resynthesising the memory init file.

---
 rtl/uart_loader.sv | 169 ++++++++++++++++
 tb/tb_uart_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// Serial boot loader: parses framed images from the UART byte stream and writes
// them into main memory as 32-bit words, holding the CPU in reset while loading.
module uart_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 5000000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxchar,
  input  logic        rxvalid,
  output logic        mem_we,
  output logic [29:0] memaddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_ADDR, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT - 1) : 32'd0;
  localparam logic [16:0] MAX_W    = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] words_q, words_d;
  logic [29:0] addr_q, addr_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tmo_q, tmo_d;
  logic        mem_we_q, mem_we_d;
  logic [29:0] memaddr_q, memaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [15:0] count_w;
  logic        in_frame;
  logic        tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      mem_we_q   <= 1'b0;
      memaddr_q  <= '0;
      wdata_q    <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      mem_we_q   <= mem_we_d;
      memaddr_q  <= memaddr_d;
      wdata_q    <= wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    words_d    = words_q;
    addr_d     = addr_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    tmo_d      = '0;
    mem_we_d   = 1'b0;
    memaddr_d  = memaddr_q;
    wdata_d    = wdata_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;

    count_w  = {words_q[7:0], rxchar};
    in_frame = (state_q inside {S_LEN, S_ADDR, S_DATA, S_CSUM});
    // A byte arriving on the expiry cycle takes priority over the timeout.
    tmo_hit  = in_frame && !rxvalid && TMO_EN && (tmo_q >= TMO_LAST);

    if (in_frame && !rxvalid && TMO_EN) tmo_d = tmo_q + 32'd1;

    if (rxvalid) begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (rxchar == SYNC_BYTE) begin
            state_d    = S_LEN;
            idx_d      = '0;
            csum_d     = '0;
            cpu_hold_d = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
          end
        end
        S_LEN: begin
          words_d = count_w;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            idx_d = '0;
            if ({1'b0, count_w} > MAX_W) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = S_ADDR;
            end
          end
        end
        S_ADDR: begin
          // Shifting into 30 bits drops address bits 31:30 on their own.
          addr_d = {addr_q[21:0], rxchar};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = (words_q == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          asm_d  = {rxchar, asm_q[23:8]};
          csum_d = csum_q + rxchar;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            mem_we_d  = 1'b1;
            memaddr_d = addr_q;
            wdata_d   = {rxchar, asm_q};
            addr_d    = addr_q + 30'd1;
            words_d   = words_q - 16'd1;
            if (words_q == 16'd1) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rxchar == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end
  end

  assign mem_we   = mem_we_q;
  assign memaddr  = memaddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed frames plus random frames, checked every cycle
// against a frame-position model of the loader.
module tb_uart_loader;

  localparam int         TMO  = 100;
  localparam int         MAXW = 4096;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [7:0]  rxchar  = 8'h00;
  logic        rxvalid = 1'b0;
  logic        mem_we;
  logic [29:0] memaddr;
  logic [31:0] wdata;
  logic        cpu_hold, done, err;

  uart_loader #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst_n), .rxchar(rxchar), .rxvalid(rxvalid),
    .mem_we(mem_we), .memaddr(memaddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the byte position inside the current frame.
  logic        m_we = 1'b0, m_hold = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [29:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          m_in = 1'b0;
  int          m_pos = 0, m_cnt = 0, m_idle = 0;
  logic [7:0]  m_hdr[6];
  logic [7:0]  m_wb[4];
  logic [7:0]  m_sum = '0;
  logic [31:0] m_base;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_we = 0; m_addr = '0; m_wdata = '0; m_hold = 0; m_done = 0; m_err = 0;
      m_in = 0; m_idle = 0; m_pos = 0; m_sum = '0;
    end else begin
      m_we = 1'b0;
      if (rxvalid) begin
        m_idle = 0;
        if (!m_in) begin
          if (rxchar == SYNC) begin
            m_in = 1; m_pos = 0; m_sum = '0; m_hold = 1; m_done = 0; m_err = 0;
          end
        end else begin
          if (m_pos < 6) begin
            m_hdr[m_pos] = rxchar;
            if (m_pos == 1) begin
              m_cnt = int'({m_hdr[0], m_hdr[1]});
              if (m_cnt > MAXW) begin m_in = 0; m_err = 1; end
            end
          end else if (m_pos < 6 + 4 * m_cnt) begin
            m_sum = m_sum + rxchar;
            m_wb[(m_pos - 6) % 4] = rxchar;
            if ((m_pos - 6) % 4 == 3) begin
              m_base  = {m_hdr[2], m_hdr[3], m_hdr[4], m_hdr[5]};
              m_we    = 1'b1;
              m_addr  = m_base[29:0] + 30'((m_pos - 6) / 4);
              m_wdata = {m_wb[3], m_wb[2], m_wb[1], m_wb[0]};
            end
          end else begin
            m_in = 0;
            if (rxchar == m_sum) begin m_done = 1; m_hold = 0; end
            else m_err = 1;
          end
          m_pos++;
        end
      end else if (m_in) begin
        m_idle++;
        if (m_idle >= TMO) begin m_in = 0; m_err = 1; end
      end
    end
  end

  typedef struct { int cyc; logic [29:0] a; logic [31:0] d; } wr_t;
  wr_t wlog[$];
  logic err_prev = 1'b0;
  int   err_rise = -1;

  initial forever begin
    @(negedge clk);
    chk("cyc_mem_we",   mem_we,   m_we);
    chk("cyc_memaddr",  memaddr,  m_addr);
    chk("cyc_wdata",    wdata,    m_wdata);
    chk("cyc_cpu_hold", cpu_hold, m_hold);
    chk("cyc_done",     done,     m_done);
    chk("cyc_err",      err,      m_err);
    if (mem_we === 1'b1) wlog.push_back('{cyc, memaddr, wdata});
    if (err === 1'b1 && err_prev !== 1'b1) err_rise = cyc;
    err_prev = err;
  end

  logic [7:0] txq[$];
  int         stq[$];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] b);
    txq.push_back(b);
  endtask

  task automatic add_hdr(input logic [15:0] c, input logic [31:0] a);
    add(SYNC); add(c[15:8]); add(c[7:0]);
    add(a[31:24]); add(a[23:16]); add(a[15:8]); add(a[7:0]);
  endtask

  task automatic add_word(input logic [31:0] w);
    add(w[7:0]); add(w[15:8]); add(w[23:16]); add(w[31:24]);
  endtask

  // rnd selects random inter-byte gaps; limit < 0 sends the whole queue.
  task automatic send_txq(input bit rnd, input int limit);
    int n, r, gap;
    n = (limit < 0 || limit > txq.size()) ? txq.size() : limit;
    stq.delete();
    for (int i = 0; i < n; i++) begin
      rxchar  = txq[i];
      rxvalid = 1'b1;
      step();
      rxvalid = 1'b0;
      stq.push_back(cyc);
      gap = 0;
      if (rnd) begin
        r = int'($urandom_range(49, 0));
        if (r == 0) gap = int'($urandom_range(101, 98));
        else if (r < 10) gap = int'($urandom_range(3, 1));
      end
      repeat (gap) step();
    end
    txq.delete();
  endtask

  int          n0, st4, st8, n, k, mode;
  logic [31:0] a;
  logic [7:0]  s, b;

  initial begin
    repeat (3) step();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_memaddr", memaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Basic two-word load
    n0 = wlog.size();
    add_hdr(16'd2, 32'h10); add_word(32'h44332211); add_word(32'h88776655);
    send_txq(0, -1);
    st4 = stq[10]; st8 = stq[14];
    chk("basic_hold_loading", cpu_hold, 1);
    add(8'h64);
    send_txq(0, -1);
    chk("basic_nwr", wlog.size() - n0, 2);
    if (wlog.size() - n0 == 2) begin
      chk("basic_a0", wlog[n0].a, 30'h10);
      chk("basic_d0", wlog[n0].d, 32'h44332211);
      chk("basic_t0", wlog[n0].cyc, st4);
      chk("basic_a1", wlog[n0+1].a, 30'h11);
      chk("basic_d1", wlog[n0+1].d, 32'h88776655);
      chk("basic_t1", wlog[n0+1].cyc, st8);
    end
    chk("basic_done", done, 1);
    chk("basic_err", err, 0);
    chk("basic_hold", cpu_hold, 0);

    // Bad checksum, then a good frame
    n0 = wlog.size();
    add_hdr(16'd2, 32'h10); add_word(32'h44332211); add_word(32'h88776655); add(8'h65);
    send_txq(0, -1);
    chk("badcs_nwr", wlog.size() - n0, 2);
    chk("badcs_err", err, 1);
    chk("badcs_done", done, 0);
    chk("badcs_hold", cpu_hold, 1);
    n0 = wlog.size();
    add_hdr(16'd1, 32'h20); add_word(32'h01020304); add(8'h0A);
    send_txq(0, -1);
    chk("good_err", err, 0);
    chk("good_done", done, 1);
    chk("good_hold", cpu_hold, 0);
    if (wlog.size() - n0 == 1) chk("good_d", wlog[n0].d, 32'h01020304);
    else chk("good_nwr", wlog.size() - n0, 1);

    // Zero count
    n0 = wlog.size();
    add_hdr(16'd0, 32'h0); add(8'h00);
    send_txq(0, -1);
    chk("zero_nwr", wlog.size() - n0, 0);
    chk("zero_done", done, 1);

    // Address wrap; bits 31:30 of ADDR are ignored
    n0 = wlog.size();
    add_hdr(16'd2, 32'hFFFF_FFFF); add_word(32'hDEADBEEF); add_word(32'h01234567); add(8'h08);
    send_txq(0, -1);
    chk("wrap_nwr", wlog.size() - n0, 2);
    if (wlog.size() - n0 == 2) begin
      chk("wrap_a0", wlog[n0].a, 30'h3FFFFFFF);
      chk("wrap_a1", wlog[n0+1].a, 30'h0);
      chk("wrap_d1", wlog[n0+1].d, 32'h01234567);
    end
    chk("wrap_done", done, 1);

    // Noise bytes, then an oversized count
    add(8'h00); add(8'hFF); add(8'hA4);
    send_txq(0, -1);
    chk("noise_done", done, 1);
    chk("noise_err", err, 0);
    chk("noise_hold", cpu_hold, 0);
    n0 = wlog.size();
    add(SYNC); add(8'h10); add(8'h01);
    send_txq(0, -1);
    chk("len_err", err, 1);
    chk("len_done", done, 0);
    chk("len_hold", cpu_hold, 1);
    add(8'h00); add(8'h00); add(8'h00); add(8'h00);
    send_txq(0, -1);
    chk("len_nwr", wlog.size() - n0, 0);

    // Timeout after two data bytes
    n0 = wlog.size();
    add_hdr(16'd1, 32'h50); add(8'h11); add(8'h22);
    send_txq(0, -1);
    st4 = stq[8];
    repeat (120) step();
    chk("tmo_err", err, 1);
    chk("tmo_delay", err_rise - st4, TMO);
    chk("tmo_nwr", wlog.size() - n0, 0);
    chk("tmo_hold", cpu_hold, 1);

    // A byte arriving exactly on the expiry cycle is accepted
    n0 = wlog.size();
    add_hdr(16'd1, 32'h60); add(8'h11); add(8'h22);
    send_txq(0, -1);
    repeat (TMO - 1) step();
    add(8'h33); add(8'h44); add(8'hAA);
    send_txq(0, -1);
    chk("edge_err", err, 0);
    chk("edge_done", done, 1);
    if (wlog.size() - n0 == 1) begin
      chk("edge_a", wlog[n0].a, 30'h60);
      chk("edge_d", wlog[n0].d, 32'h44332211);
    end else chk("edge_nwr", wlog.size() - n0, 1);

    // Reset in the middle of a word
    add_hdr(16'd1, 32'h70); add(8'hAA); add(8'hBB); add(8'hCC);
    send_txq(0, -1);
    n0 = wlog.size();
    rst_n = 1'b0;
    #1;
    chk("mrst_mem_we", mem_we, 0);
    chk("mrst_memaddr", memaddr, 0);
    chk("mrst_wdata", wdata, 0);
    chk("mrst_hold", cpu_hold, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    repeat (3) step();
    rst_n = 1'b1;
    add(8'hDD);
    send_txq(0, -1);
    repeat (10) step();
    chk("mrst_nwr", wlog.size() - n0, 0);
    add_hdr(16'd1, 32'h71); add_word(32'h04030201); add(8'h0A);
    send_txq(0, -1);
    chk("fresh_done", done, 1);
    if (wlog.size() - n0 == 1) begin
      chk("fresh_a", wlog[n0].a, 30'h71);
      chk("fresh_d", wlog[n0].d, 32'h04030201);
    end else chk("fresh_nwr", wlog.size() - n0, 1);

    // Random frames: noise, good/bad checksums, oversize counts, truncation
    for (int f = 0; f < 40; f++) begin
      k = int'($urandom_range(2, 0));
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        add(b);
      end
      n    = int'($urandom_range(5, 0));
      a    = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
      mode = int'($urandom_range(7, 0));
      if (mode == 2) begin
        add(SYNC); add(8'h10); add(8'($urandom_range(255, 1)));
        send_txq(1, -1);
      end else begin
        add_hdr(16'(n), a);
        s = 8'h00;
        for (int j = 0; j < 4 * n; j++) begin
          b = 8'($urandom);
          s = s + b;
          add(b);
        end
        add((mode == 0) ? s + 8'h01 : s);
        if (mode == 1) begin
          send_txq(1, int'($urandom_range(txq.size() - 1, 1)));
          repeat (TMO + 10) step();
        end else begin
          send_txq(1, -1);
        end
      end
      repeat (3) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
